// File: rtl/Sbox.sv
// Sbox: AES forward byte substitution (FIPS-197 S-box), purely combinational.
// Ports:
//   in_byte  - byte to substitute
//   out_byte - substituted byte
module Sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the most significant byte, entry 255 in the least.
    localparam logic [2047:0] Table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // (255 - k) * 8 == {~k, 3'b000} for an 8-bit k.
    always_comb begin
        out_byte = Table[{~in_byte, 3'b000} +: 8];
    end

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule. Loads a cipher key and streams
// round keys 0..10 over a valid/ready handshake, one key per accepted transfer.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-high reset
//   start, key_in      - begin expansion of key_in (sampled only while idle)
//   rk_ready           - downstream accepts round_key this cycle
//   rk_valid           - round_key / rk_index are valid
//   rk_index           - round number 0..10 of round_key
//   round_key          - current round key, [127:96] = w0
//   busy               - expansion in progress
//   done               - one-cycle pulse after round key 10 is accepted
// Optional (macro AES_KEY_STORE_EN):
//   rd_idx, rd_key     - registered read port of an 11-entry round-key store
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
`ifdef AES_KEY_STORE_EN
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
`endif
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         done
);

    typedef enum logic {StIdle, StEmit} state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q;
    logic [3:0]   idx_q;
    logic [7:0]   rcon_q;
    logic         done_q;

    logic         xfer;
    logic         last;
    logic [127:0] key_next;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t, n0, n1, n2, n3;
    logic [7:0]   rcon_next;

    assign xfer = (state_q == StEmit) && rk_ready;
    assign last = (idx_q == 4'd10);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StEmit;
            StEmit: if (xfer && last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        rk_valid = 1'b0;
        busy     = 1'b0;
        if (state_q == StEmit) begin
            rk_valid = 1'b1;
            busy     = 1'b1;
        end
    end

    assign rk_index  = idx_q;
    assign round_key = key_q;
    assign done      = done_q;

    // Next round key: SubWord(RotWord(w3)) ^ rcon, then the chained word XORs.
    assign rot_w3 = {key_q[23:0], key_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        Sbox u_sbox (
            .in_byte  (rot_w3[8*b +: 8]),
            .out_byte (sub_w3[8*b +: 8])
        );
    end

    assign t  = sub_w3 ^ {rcon_q, 24'h0};
    assign n0 = key_q[127:96] ^ t;
    assign n1 = key_q[95:64] ^ n0;
    assign n2 = key_q[63:32] ^ n1;
    assign n3 = key_q[31:0] ^ n2;
    assign key_next = {n0, n1, n2, n3};

    // xtime in GF(2^8)
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            idx_q  <= '0;
            rcon_q <= 8'h01;
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (state_q == StIdle && start) begin
                key_q  <= key_in;
                idx_q  <= '0;
                rcon_q <= 8'h01;
            end else if (xfer && !last) begin
                key_q  <= key_next;
                idx_q  <= idx_q + 4'd1;
                rcon_q <= rcon_next;
            end
        end
    end

`ifdef AES_KEY_STORE_EN
    logic [127:0] store_q [0:10];
    logic [127:0] rd_key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                store_q[i] <= '0;
            end
            rd_key_q <= '0;
        end else begin
            if (xfer) begin
                store_q[idx_q] <= key_q;
            end
            if (rd_idx <= 4'd10) begin
                rd_key_q <= store_q[rd_idx];
            end else begin
                rd_key_q <= '0;
            end
        end
    end

    assign rd_key = rd_key_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every accepted transfer.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         busy;
    logic         done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
`ifdef AES_KEY_STORE_EN
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
`endif
        .rk_valid  (rk_valid),
        .rk_index  (rk_index),
        .round_key (round_key),
        .busy      (busy),
        .done      (done)
    );

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZeroRk1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] FipsRk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           chk_key;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pop on every transfer, done and stall-stability checks.
    logic         prev_stall = 1'b0;
    logic         final_prev = 1'b0;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            final_prev = 1'b0;
        end else begin
            check("done", {127'b0, done}, {127'b0, final_prev});
            if (prev_stall) begin
                check("stall_key", round_key, prev_key);
                check("stall_idx", {124'b0, rk_index}, {124'b0, prev_idx});
            end
            if (rk_valid && rk_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer: got index %0d want none", rk_index);
                end else begin
                    e = sb.pop_front();
                    check("rk_index", {124'b0, rk_index}, {124'b0, e.idx});
                    if (e.chk_key) check("round_key", round_key, e.key);
                end
            end
            prev_stall = rk_valid && !rk_ready;
            prev_key   = round_key;
            prev_idx   = rk_index;
            final_prev = rk_valid && rk_ready && (rk_index == 4'd10);
        end
    end

    task automatic push_seq(input bit fips);
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            e.idx     = 4'(i);
            e.key     = fips ? FipsRk[i] : (i == 1 ? ZeroRk1 : 128'h0);
            e.chk_key = fips || (i <= 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic [127:0] k);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = {4{32'hdeadbeef}};
    endtask

    // Counts edges until done; randomises rk_ready each cycle when rnd is set.
    task automatic wait_done(output int n, input bit rnd);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            if (rnd && !done) rk_ready = 1'($urandom_range(0, 1));
        end
        rk_ready = 1'b1;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done want done within 300 cycles");
        end
    endtask

    task automatic wait_index(input logic [3:0] idx);
        int n = 0;
        while (rk_index != idx && n < 50) begin
            @(posedge clk);
            n++;
            #1;
        end
        if (rk_index != idx) begin
            checks++;
            failures++;
            $display("FAIL index_timeout: got %0d want %0d", rk_index, idx);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b1;
`ifdef AES_KEY_STORE_EN
        rd_idx   = 4'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {127'b0, rk_valid}, 128'h0);
        check("rst_busy", {127'b0, busy}, 128'h0);
        check("rst_done", {127'b0, done}, 128'h0);
        check("rst_index", {124'b0, rk_index}, 128'h0);
        check("rst_key", round_key, 128'h0);
        rst = 1'b0;

        // FIPS-197 key, no stalls
        push_seq(1'b1);
        do_start(FipsKey);
        check("busy_after_start", {127'b0, busy}, 128'h1);
        wait_done(n, 1'b0);
        check("done_latency", 128'(n), 128'd11);
        check("busy_at_done", {127'b0, busy}, 128'h0);
        check("sb_drained_fips", 128'(sb.size()), 128'h0);

`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd10;
        @(posedge clk);
        #1;
        check("store_rd10", rd_key, FipsRk[10]);
        rd_idx = 4'd15;
        @(posedge clk);
        #1;
        check("store_rd15", rd_key, 128'h0);
        rd_idx = 4'd0;
`endif

        // All-zero key
        push_seq(1'b0);
        do_start(128'h0);
        wait_done(n, 1'b0);
        check("sb_drained_zero", 128'(sb.size()), 128'h0);

        // Random stalls on the FIPS key
        push_seq(1'b1);
        do_start(FipsKey);
        wait_done(n, 1'b1);
        check("sb_drained_stall", 128'(sb.size()), 128'h0);

        // start with a different key mid-expansion is ignored
        push_seq(1'b1);
        do_start(FipsKey);
        wait_index(4'd5);
        start  = 1'b1;
        key_in = 128'h0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        check("busy_ignore_start", {127'b0, busy}, 128'h1);
        wait_done(n, 1'b0);
        check("sb_drained_ignore", 128'(sb.size()), 128'h0);

        // Reset mid-expansion aborts without done
        push_seq(1'b1);
        do_start(FipsKey);
        wait_index(4'd4);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("abort_valid", {127'b0, rk_valid}, 128'h0);
        check("abort_busy", {127'b0, busy}, 128'h0);
        check("abort_done", {127'b0, done}, 128'h0);
        check("abort_index", {124'b0, rk_index}, 128'h0);
        check("abort_key", round_key, 128'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", {127'b0, done}, 128'h0);
        push_seq(1'b1);
        do_start(FipsKey);
        wait_done(n, 1'b0);
        check("restart_latency", 128'(n), 128'd11);
        check("sb_drained_restart", 128'(sb.size()), 128'h0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
